// File: rtl/im_arbiter_pkg.sv
// Shared definitions for the instruction-memory port arbiter: FSM encoding,
// address-map defaults and the exception cause reported for bad loader writes.
package im_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_RUN    = 2'd2,
    ST_REFILL = 2'd3
  } arb_state_e;

  localparam int unsigned IM_ADDR_W  = 11;
  localparam logic [31:0] IM_BASE    = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT   = 32'h0000_4ffc;
  localparam int unsigned IM_MAX_RUN = 4;

  // ExcCode values; an illegal loader write is reported as a store address error
  localparam logic [4:0] EXC_ADEL       = 5'd4;
  localparam logic [4:0] EXC_ADES       = 5'd5;
  localparam logic [4:0] EXC_LD_ILLEGAL = EXC_ADES;

endpackage

// File: rtl/im_arbiter_if.sv
// Fetch, loader and block-RAM signals of the instruction-memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface im_arbiter_if #(
  parameter int unsigned ADDR_W = 11
);
  logic [31:0]       f_addr;
  logic [31:0]       f_instr;
  logic              stall_F;
  logic              ld_req;
  logic [31:0]       ld_addr;
  logic [31:0]       ld_wdata;
  logic              ld_gnt;
  logic              ld_err;
  logic              boot_done;
  logic              booting;
  logic [ADDR_W-1:0] im_addr;
  logic              im_we;
  logic [31:0]       im_wdata;
  logic [31:0]       im_rdata;

  modport slave (
    input  f_addr, ld_req, ld_addr, ld_wdata, boot_done, im_rdata,
    output f_instr, stall_F, ld_gnt, ld_err, booting, im_addr, im_we, im_wdata
  );

  modport master (
    output f_addr, ld_req, ld_addr, ld_wdata, boot_done, im_rdata,
    input  f_instr, stall_F, ld_gnt, ld_err, booting, im_addr, im_we, im_wdata
  );
endinterface

// File: rtl/im_addr_xlate.sv
// Byte address to IM word index translation plus loader legality check
// (word aligned and inside [BASE, LIMIT]).
module im_addr_xlate
  import im_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = IM_ADDR_W,
  parameter logic [31:0] BASE   = IM_BASE,
  parameter logic [31:0] LIMIT  = IM_LIMIT
) (
  input  logic [31:0]       addr_i,
  output logic [ADDR_W-1:0] idx_o,
  output logic              legal_o
);

  assign idx_o   = ADDR_W'((addr_i - BASE) >> 2);
  assign legal_o = (addr_i[1:0] == 2'b00) && (addr_i >= BASE) && (addr_i <= LIMIT);

endmodule

// File: rtl/im_arbiter.sv
// Shares the single IM block-RAM port between fetch and the program loader,
// holding the CPU in BOOT until the image is loaded.
module im_arbiter
  import im_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = IM_ADDR_W,
  parameter logic [31:0] BASE    = IM_BASE,
  parameter logic [31:0] LIMIT   = IM_LIMIT,
  parameter int unsigned MAX_RUN = IM_MAX_RUN
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  im_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(MAX_RUN + 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic              ld_err_q;
  logic              fetch_rd_q, fetch_rd;
  logic [31:0]       hold_q;

  logic [ADDR_W-1:0] f_idx, ld_idx;
  logic              ld_legal;
  logic              unused_f_legal;
  logic              gnt, we, stall, boot;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;

  im_addr_xlate #(.ADDR_W(ADDR_W), .BASE(BASE), .LIMIT(LIMIT)) u_xlate_f (
    .addr_i  (bus.f_addr),
    .idx_o   (f_idx),
    .legal_o (unused_f_legal)
  );

  im_addr_xlate #(.ADDR_W(ADDR_W), .BASE(BASE), .LIMIT(LIMIT)) u_xlate_ld (
    .addr_i  (bus.ld_addr),
    .idx_o   (ld_idx),
    .legal_o (ld_legal)
  );

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    gnt       = 1'b0;
    we        = 1'b0;
    stall     = 1'b1;
    boot      = 1'b0;
    addr      = '0;
    wdata     = '0;
    fetch_rd  = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        boot = 1'b1;
        if (bus.ld_req) begin
          gnt   = 1'b1;
          we    = ld_legal;
          addr  = ld_idx;
          wdata = bus.ld_wdata;
        end
        if (bus.boot_done) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        addr      = f_idx;
        fetch_rd  = 1'b1;
        run_cnt_d = '0;
        state_d   = ST_RUN;
      end
      ST_RUN, ST_REFILL: begin
        // REFILL re-reads the stalled PC so RUN resumes with valid f_instr
        stall   = (state_q == ST_REFILL);
        addr    = f_idx;
        state_d = ST_RUN;
        if (bus.ld_req && (run_cnt_q < CNT_W'(MAX_RUN))) begin
          gnt       = 1'b1;
          we        = ld_legal;
          addr      = ld_idx;
          wdata     = bus.ld_wdata;
          stall     = 1'b1;
          run_cnt_d = run_cnt_q + 1'b1;
          state_d   = ST_REFILL;
        end else begin
          fetch_rd = 1'b1;
          if (bus.ld_req || !stall) run_cnt_d = '0;
        end
      end
    endcase
    // outputs follow reset immediately, not at the next edge
    if (!rst_ni) begin
      gnt      = 1'b0;
      we       = 1'b0;
      stall    = 1'b1;
      boot     = 1'b1;
      addr     = '0;
      wdata    = '0;
      fetch_rd = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_BOOT;
      run_cnt_q  <= '0;
      ld_err_q   <= 1'b0;
      fetch_rd_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      ld_err_q   <= gnt & ~ld_legal;
      fetch_rd_q <= fetch_rd;
      if (fetch_rd_q) hold_q <= bus.im_rdata;
    end
  end

  assign bus.ld_gnt   = gnt;
  assign bus.im_we    = we;
  assign bus.stall_F  = stall;
  assign bus.booting  = boot;
  assign bus.im_addr  = addr;
  assign bus.im_wdata = wdata;
  assign bus.ld_err   = ld_err_q;
  assign bus.f_instr  = fetch_rd_q ? bus.im_rdata : hold_q;

endmodule

// File: tb/tb_im_arbiter.sv
// Directed bench for im_arbiter: boot load, illegal loader writes, runtime
// patch, starvation guard, boot_done/ld_req collision and async reset.
module tb_im_arbiter;
  import im_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [0:2047];

  im_arbiter_if #(.ADDR_W(11)) bus ();

  im_arbiter dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // read-first single-port block RAM
  always @(posedge clk) begin
    if (bus.im_we) mem[bus.im_addr] <= bus.im_wdata;
    bus.im_rdata <= mem[bus.im_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.f_addr    = 32'h3000;
    bus.ld_req    = 1'b0;
    bus.ld_addr   = 32'h0;
    bus.ld_wdata  = 32'h0;
    bus.boot_done = 1'b0;
    rst_n         = 1'b0;

    // reset held; a pending loader request must not leak through
    @(negedge clk); @(negedge clk);
    bus.ld_req  = 1'b1;
    bus.ld_addr = 32'h3004;
    bus.ld_wdata = 32'h1234_5678;
    @(negedge clk); #1;
    chk("rst_stall",   32'(bus.stall_F), 32'd1);
    chk("rst_booting", 32'(bus.booting), 32'd1);
    chk("rst_gnt",     32'(bus.ld_gnt),  32'd0);
    chk("rst_we",      32'(bus.im_we),   32'd0);
    chk("rst_addr",    32'(bus.im_addr), 32'd0);
    chk("rst_wdata",   bus.im_wdata,     32'd0);
    chk("rst_err",     32'(bus.ld_err),  32'd0);
    chk("rst_instr",   bus.f_instr,      32'd0);

    // boot image
    @(negedge clk);
    rst_n        = 1'b1;
    bus.ld_addr  = 32'h3000;
    bus.ld_wdata = 32'h2408_0001;
    #1;
    chk("boot0_gnt",   32'(bus.ld_gnt),  32'd1);
    chk("boot0_we",    32'(bus.im_we),   32'd1);
    chk("boot0_addr",  32'(bus.im_addr), 32'd0);
    chk("boot0_wdata", bus.im_wdata,     32'h2408_0001);
    chk("boot0_stall", 32'(bus.stall_F), 32'd1);
    @(negedge clk);
    bus.ld_addr  = 32'h3004;
    bus.ld_wdata = 32'h0000_0000;
    #1;
    chk("boot1_we",   32'(bus.im_we),   32'd1);
    chk("boot1_addr", 32'(bus.im_addr), 32'd1);

    // illegal: misaligned, then beyond LIMIT (both alias word 0)
    @(negedge clk);
    bus.ld_addr  = 32'h3002;
    bus.ld_wdata = 32'hBAD0_0001;
    #1;
    chk("ill_mis_gnt", 32'(bus.ld_gnt), 32'd1);
    chk("ill_mis_we",  32'(bus.im_we),  32'd0);
    chk("ill_mis_err_early", 32'(bus.ld_err), 32'd0);
    @(negedge clk);
    bus.ld_addr  = 32'h5000;
    bus.ld_wdata = 32'hBAD0_0002;
    #1;
    chk("ill_mis_err", 32'(bus.ld_err), 32'd1);
    chk("ill_hi_gnt",  32'(bus.ld_gnt), 32'd1);
    chk("ill_hi_we",   32'(bus.im_we),  32'd0);
    @(negedge clk);
    bus.ld_addr  = 32'h4ffc;
    bus.ld_wdata = 32'hA5A5_A5A5;
    #1;
    chk("ill_hi_err", 32'(bus.ld_err),  32'd1);
    chk("limit_we",   32'(bus.im_we),   32'd1);
    chk("limit_addr", 32'(bus.im_addr), 32'h7ff);
    @(negedge clk);
    bus.ld_addr  = 32'h2ffc;
    bus.ld_wdata = 32'hBAD0_0003;
    #1;
    chk("limit_err",   32'(bus.ld_err), 32'd0);
    chk("ill_base_we", 32'(bus.im_we),  32'd0);
    @(negedge clk);
    bus.ld_req    = 1'b0;
    bus.boot_done = 1'b1;
    #1;
    chk("ill_base_err", 32'(bus.ld_err),  32'd1);
    chk("bd_stall",     32'(bus.stall_F), 32'd1);
    chk("bd_booting",   32'(bus.booting), 32'd1);

    // DRAIN
    @(negedge clk);
    bus.boot_done = 1'b0;
    #1;
    chk("drain_stall",   32'(bus.stall_F), 32'd1);
    chk("drain_booting", 32'(bus.booting), 32'd0);
    chk("drain_addr",    32'(bus.im_addr), 32'd0);
    // first RUN cycle
    @(negedge clk); #1;
    chk("run1_stall", 32'(bus.stall_F), 32'd0);
    chk("run1_addr",  32'(bus.im_addr), 32'd0);
    @(negedge clk);
    bus.f_addr = 32'h4ffc;
    #1;
    chk("run2_instr", bus.f_instr, 32'h2408_0001);
    @(negedge clk);
    bus.f_addr = 32'h3010;
    #1;
    chk("limit_instr", bus.f_instr, 32'hA5A5_A5A5);

    // runtime patch of the word under the PC
    @(negedge clk);
    bus.ld_req   = 1'b1;
    bus.ld_addr  = 32'h3010;
    bus.ld_wdata = 32'h1000_FFFF;
    #1;
    chk("patch_gnt",   32'(bus.ld_gnt),  32'd1);
    chk("patch_stall", 32'(bus.stall_F), 32'd1);
    chk("patch_we",    32'(bus.im_we),   32'd1);
    chk("patch_addr",  32'(bus.im_addr), 32'd4);
    @(negedge clk);
    bus.ld_req = 1'b0;
    #1;
    chk("refill_stall", 32'(bus.stall_F), 32'd1);
    chk("refill_gnt",   32'(bus.ld_gnt),  32'd0);
    chk("refill_addr",  32'(bus.im_addr), 32'd4);
    @(negedge clk); #1;
    chk("patch_resume_stall", 32'(bus.stall_F), 32'd0);
    chk("patch_instr",        bus.f_instr,      32'h1000_FFFF);

    // starvation guard: 4 grants then one forced fetch, twice
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.ld_req   = 1'b1;
      bus.ld_addr  = 32'h3100 + 32'(i) * 4;
      bus.ld_wdata = 32'h5000_0000 + 32'(i);
      #1;
      chk("starve_gnt",   32'(bus.ld_gnt),  (i == 4 || i == 9) ? 32'd0 : 32'd1);
      chk("starve_stall", 32'(bus.stall_F), 32'd1);
      if (i == 4) chk("starve_fetch_addr", 32'(bus.im_addr), 32'd4);
    end
    @(negedge clk);
    bus.ld_req = 1'b0;
    #1;
    chk("starve_end_stall", 32'(bus.stall_F), 32'd0);
    chk("starve_end_instr", bus.f_instr,      32'h1000_FFFF);

    // reset in the middle of REFILL
    @(negedge clk);
    bus.ld_req   = 1'b1;
    bus.ld_addr  = 32'h3200;
    bus.ld_wdata = 32'h7777_7777;
    @(negedge clk); #1;
    chk("pre_rst_refill_gnt", 32'(bus.ld_gnt), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt",     32'(bus.ld_gnt),  32'd0);
    chk("mid_rst_stall",   32'(bus.stall_F), 32'd1);
    chk("mid_rst_booting", 32'(bus.booting), 32'd1);
    chk("mid_rst_we",      32'(bus.im_we),   32'd0);
    chk("mid_rst_addr",    32'(bus.im_addr), 32'd0);
    chk("mid_rst_wdata",   bus.im_wdata,     32'd0);
    chk("mid_rst_err",     32'(bus.ld_err),  32'd0);
    chk("mid_rst_instr",   bus.f_instr,      32'd0);

    // ld_req and boot_done together in BOOT
    bus.ld_req = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n         = 1'b1;
    bus.f_addr    = 32'h3008;
    bus.ld_req    = 1'b1;
    bus.ld_addr   = 32'h3008;
    bus.ld_wdata  = 32'hCAFE_F00D;
    bus.boot_done = 1'b1;
    #1;
    chk("sim_booting", 32'(bus.booting), 32'd1);
    chk("sim_gnt",     32'(bus.ld_gnt),  32'd1);
    chk("sim_we",      32'(bus.im_we),   32'd1);
    @(negedge clk);
    bus.boot_done = 1'b0;
    bus.ld_addr   = 32'h300c;
    bus.ld_wdata  = 32'h1111_1111;
    #1;
    chk("sim_drain_gnt",     32'(bus.ld_gnt),  32'd0);
    chk("sim_drain_we",      32'(bus.im_we),   32'd0);
    chk("sim_drain_booting", 32'(bus.booting), 32'd0);
    chk("sim_drain_stall",   32'(bus.stall_F), 32'd1);
    chk("sim_drain_addr",    32'(bus.im_addr), 32'd2);
    @(negedge clk);
    bus.ld_req = 1'b0;
    #1;
    chk("sim_run_stall", 32'(bus.stall_F), 32'd0);
    chk("sim_run_instr", bus.f_instr,      32'hCAFE_F00D);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/im_arbiter.md
Name: im_arbiter

Overview:
- Owns the single port of the instruction-memory block RAM and shares it between two requesters: the fetch stage (read by PC) and the program loader (word writes from the UART boot path).
- Sequences boot: the CPU is held until the loader finishes, then run-time patch writes are permitted with a starvation guard for fetch.
- Sits between the fetch stage's PC register and the IM block RAM.
- Drives the fetch-stage stall.

Parameters:
- ADDR_W, 11, IM word-address width (2048 words)
- BASE, 32'h3000, byte address of IM word 0
- LIMIT, 32'h4ffc, highest legal loader byte address
- MAX_RUN, 4, maximum consecutive loader grants in RUN before fetch is forced one cycle

Ports:
- clk  in  1  single system clock; BRAM is clocked on the same edge
- reset  in  1  asynchronous, active-low reset
- f_addr  in  32  fetch PC, byte address
- f_instr  out  32  instruction for the fetch stage
- stall_F  out  1  freeze PC and F/D register
- ld_req  in  1  loader write request, held until ld_gnt
- ld_addr  in  32  loader byte address
- ld_wdata  in  32  loader write data
- ld_gnt  out  1  request consumed this cycle
- ld_err  out  1  one-cycle pulse: previous granted request was illegal
- boot_done  in  1  loader finished initial image; level or pulse
- booting  out  1  high while in BOOT
- im_addr  out  ADDR_W  BRAM word address
- im_we  out  1  BRAM write enable
- im_wdata  out  32  BRAM write data
- im_rdata  in  32  BRAM read data, valid one cycle after im_addr

Behaviour:
- Address translation: word index = (addr - BASE)[ADDR_W+1:2]. This rule applies to both requesters.
- Loader legality: the request is legal only when addr[1:0]==0 and BASE<=addr<=LIMIT.
- Illegal loader request handling: ld_gnt is still asserted (the request is consumed), im_we=0, and ld_err=1 on the following cycle.
- Fetch range and alignment checks remain in the fetch stage and are not done here.
- States: BOOT, DRAIN, RUN, REFILL.
- BOOT:
  - stall_F=1, booting=1.
  - If ld_req, then ld_gnt=1, im_addr and im_wdata come from the loader, and im_we=legal.
  - boot_done=1 moves to DRAIN. If ld_req and boot_done arrive in the same cycle, the write is performed first, then the state goes to DRAIN.
- DRAIN:
  - Exactly 1 cycle. stall_F=1, im_addr=fetch index, ld_gnt=0.
  - Moves to RUN.
- RUN:
  - Default: im_addr=fetch index, im_we=0, stall_F=0.
  - If ld_req and run_cnt<MAX_RUN: grant the loader, stall_F=1, run_cnt++, move to REFILL.
  - If ld_req and run_cnt==MAX_RUN: ld_gnt=0, fetch reads, run_cnt clears to 0.
- REFILL:
  - stall_F=1, im_addr=fetch index (re-read of the stalled PC).
  - A further ld_req in REFILL is granted under the same run_cnt rule and REFILL is re-entered. Otherwise the state returns to RUN.
  - run_cnt clears whenever a fetch read completes with stall_F=0.
- f_instr: a hold register captures im_rdata on the cycle after a fetch read. f_instr = im_rdata when the previous cycle was a fetch read, otherwise the hold value.
- Latency:
  - Fetch read: 1 cycle, unchanged from the un-arbitrated BRAM path.
  - Loader write: visible to a fetch read issued the next cycle.
- boot_done is ignored outside BOOT. Returning to BOOT requires reset.
- Reset (async, any state, mid-write included) forces:
  - state=BOOT, stall_F=1, booting=1, ld_gnt=0, ld_err=0, im_we=0
  - im_addr=0, im_wdata=0, run_cnt=0, hold register=0
- Reset deassertion is synchronised by the top level, not here.
- The grant logic combines state with ld_req. ld_gnt, im_we and stall_F are combinational from state and ld_req. ld_err and the hold register are registered.

Decomposition:
- Shared header: state encodings (BOOT=2'd0, DRAIN=2'd1, RUN=2'd2, REFILL=2'd3), BASE/LIMIT defaults, and the ld_err cause code alongside the existing ExcCode defines.
- One natural sub-module, im_addr_xlate: combinational byte-to-word translation plus the legality check. It is instantiated twice (fetch, loader).
- Everything else stays in im_arbiter.

Test Plan:
- Boot load: reset low 3 cycles then high; write 0x3000<=0x24080001 and 0x3004<=0x00000000; boot_done pulse -> stall_F=1 until DRAIN ends, first RUN cycle drives im_addr=0, next cycle f_instr=0x24080001.
- Illegal loader address: in BOOT, ld_addr=0x3002 then 0x5000 -> ld_gnt=1 each time, im_we=0, ld_err=1 the following cycle; memory unchanged.
- Runtime patch: in RUN with f_addr=0x3010, single ld_req to 0x3010 with 0x1000FFFF -> stall_F=1 for 2 cycles (grant, REFILL), then f_instr=0x1000FFFF.
- Starvation guard: MAX_RUN=4, ld_req held 10 cycles in RUN -> grant pattern 4 granted, 1 fetch, 4 granted, 1 fetch; fetch completes at least one read every 5 cycles.
- Simultaneous ld_req+boot_done in BOOT -> write performed, next state DRAIN; ld_req the next cycle gets ld_gnt=0.
- Reset mid-REFILL -> all outputs take their reset values immediately without waiting for a clock edge; booting=1.
